// File: rtl/regfile_dump_reader.sv
// Walks register-file addresses 0..DEPTH-1 and streams (addr, data) beats on valid/ready.
// Optional even-parity output on each beat when REGDUMP_PARITY_EN is defined.
module regfile_dump_reader #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 32,
  parameter int ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_SIZE-1:0] rf_addr,
  input  logic [WIDTH-1:0]     rf_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_SIZE-1:0] out_addr,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
`ifdef REGDUMP_PARITY_EN
  ,
  output logic                 out_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic [ADDR_SIZE-1:0]   r_outAddr;
  logic [WIDTH-1:0]       r_outData;
  logic                   r_outLast;
  logic                   w_handshake;
  logic                   w_isLastAddr;

  assign w_handshake  = (r_state == HOLD) && out_ready;
  assign w_isLastAddr = (r_addr == ADDR_SIZE'(DEPTH - 1));

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (start) w_stateNext = READ;
      READ: w_stateNext = HOLD;
      HOLD: if (w_handshake) w_stateNext = r_outLast ? DONE : READ;
      DONE: w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_outAddr <= '0;
      r_outData <= '0;
      r_outLast <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      case (r_state)
        IDLE: if (start) r_addr <= '0;
        READ: begin
          r_outData <= rf_rdata;
          r_outAddr <= r_addr;
          r_outLast <= w_isLastAddr;
        end
        // Termination relies on r_outLast, so the counter never steps past DEPTH-1.
        HOLD: if (w_handshake && !r_outLast) r_addr <= r_addr + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef REGDUMP_PARITY_EN
  logic r_outParity;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outParity <= 1'b0;
    end else if (r_state == READ) begin
      r_outParity <= ^rf_rdata;
    end
  end

  assign out_parity = r_outParity;
`endif

  assign rf_addr   = (r_state == IDLE) ? '0 : r_addr;
  assign out_valid = (r_state == HOLD);
  assign out_addr  = r_outAddr;
  assign out_data  = r_outData;
  assign out_last  = r_outLast;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: DEPTH=32 main instance plus a DEPTH=5 instance.
// Define REGDUMP_PARITY_EN to also exercise the parity output.
module tb_regfile_dump_reader;

  typedef struct {
    int          addr;
    logic [15:0] data;
    bit          last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  rf_addr;
  logic [15:0] rf_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_addr;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic        start5 = 1'b0;
  logic [2:0]  rf_addr5;
  logic [15:0] rf_rdata5;
  logic        out_valid5;
  logic        out_ready5 = 1'b0;
  logic [2:0]  out_addr5;
  logic [15:0] out_data5;
  logic        out_last5;
  logic        busy5;
  logic        done5;

`ifdef REGDUMP_PARITY_EN
  logic        out_parity;
  logic        out_parity5;
`endif

  logic [15:0] rf [32];
  logic [15:0] rf5 [8];
  beat_t       sbq[$];
  int          passCount = 0;
  int          checkCount = 0;

  assign rf_rdata  = rf[rf_addr];
  assign rf_rdata5 = rf5[rf_addr5];

  always #5 clk = ~clk;

  regfile_dump_reader #(.WIDTH(16), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef REGDUMP_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  regfile_dump_reader #(.WIDTH(16), .DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .rf_addr(rf_addr5), .rf_rdata(rf_rdata5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_addr(out_addr5), .out_data(out_data5),
    .out_last(out_last5), .busy(busy5), .done(done5)
`ifdef REGDUMP_PARITY_EN
    , .out_parity(out_parity5)
`endif
  );

  task automatic loadAndPush();
    sbq.delete();
    for (int i = 0; i < 32; i++) rf[i] = 16'(i * 3 + 1);
    for (int i = 0; i < 32; i++) sbq.push_back('{i, rf[i], i == 31});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({out_valid, busy, done, rf_addr, out_addr, out_data, out_last} !== '0)
      $display("[TB] FAIL reset_state got valid=%b busy=%b done=%b rf_addr=%0d addr=%0d data=%h last=%b want all 0",
               out_valid, busy, done, rf_addr, out_addr, out_data, out_last);
    else passCount++;
    checkCount++;
    if ({out_valid5, busy5, done5} !== 3'b000)
      $display("[TB] FAIL reset_state5 got valid=%b busy=%b done=%b want 0", out_valid5, busy5, done5);
    else passCount++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int beats = 0, dones = 0, lastHs = -1, doneIdx = -1;
    beat_t b;
    loadAndPush();
    out_ready = 1'b1;
    start = 1'b1;
    for (int n = 0; n < 200 && dones == 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 0) begin
        checkCount++;
        if ({out_valid, busy, rf_addr} !== {1'b0, 1'b1, 5'd0})
          $display("[TB] FAIL basic_read_cycle got valid=%b busy=%b rf_addr=%0d want 0 1 0", out_valid, busy, rf_addr);
        else passCount++;
      end
      if (n == 1) begin
        checkCount++;
        if (out_valid !== 1'b1) $display("[TB] FAIL basic_latency got valid=%b want 1", out_valid);
        else passCount++;
      end
      if (done === 1'b1) begin dones++; doneIdx = n; end
      if (out_valid === 1'b1 && out_ready) begin
        b = sbq.pop_front();
        checkCount++;
        if ({out_addr, out_data, out_last} !== {b.addr[4:0], b.data, b.last})
          $display("[TB] FAIL basic_beat got addr=%0d data=%h last=%b want addr=%0d data=%h last=%b",
                   out_addr, out_data, out_last, b.addr, b.data, b.last);
        else passCount++;
        beats++;
        lastHs = n;
      end
    end
    checkCount++;
    if (beats !== 32 || dones !== 1) $display("[TB] FAIL basic_counts got beats=%0d dones=%0d want 32 1", beats, dones);
    else passCount++;
    checkCount++;
    if (lastHs !== 63 || doneIdx !== 64)
      $display("[TB] FAIL basic_timing got lastHs=%0d doneIdx=%0d want 63 64", lastHs, doneIdx);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if ({done, busy} !== 2'b00) $display("[TB] FAIL basic_idle got done=%b busy=%b want 0 0", done, busy);
    else passCount++;
  endtask

  task automatic test_backpressure();
    int beats = 0, dones = 0;
    bit stalled = 0;
    beat_t b;
    loadAndPush();
    out_ready = 1'b1;
    start = 1'b1;
    for (int n = 0; n < 300 && dones == 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (!stalled && out_valid === 1'b1 && out_addr == 5'd7) begin
        stalled = 1;
        out_ready = 1'b0;
        rf[7] = 16'hBEEF;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          rf[7] = 16'(16'hBEEF + s);
          checkCount++;
          if ({out_valid, out_addr, out_data} !== {1'b1, 5'd7, 16'h0016})
            $display("[TB] FAIL stall_hold got valid=%b addr=%0d data=%h want 1 7 0016", out_valid, out_addr, out_data);
          else passCount++;
        end
        rf[7] = 16'h0016;
        out_ready = 1'b1;
      end
      if (done === 1'b1) dones++;
      if (out_valid === 1'b1 && out_ready) begin
        b = sbq.pop_front();
        checkCount++;
        if ({out_addr, out_data, out_last} !== {b.addr[4:0], b.data, b.last})
          $display("[TB] FAIL stall_beat got addr=%0d data=%h last=%b want addr=%0d data=%h last=%b",
                   out_addr, out_data, out_last, b.addr, b.data, b.last);
        else passCount++;
        beats++;
      end
    end
    checkCount++;
    if (beats !== 32 || dones !== 1 || !stalled)
      $display("[TB] FAIL stall_counts got beats=%0d dones=%0d stalled=%0d want 32 1 1", beats, dones, stalled);
    else passCount++;
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    int beats = 0, dones = 0, extraValid = 0;
    beat_t b;
    loadAndPush();
    out_ready = 1'b1;
    start = 1'b1;
    for (int n = 0; n < 200 && dones == 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid === 1'b1 && (out_addr == 5'd3 || out_addr == 5'd31)) start = 1'b1;
      if (done === 1'b1) begin dones++; start = 1'b1; end
      if (out_valid === 1'b1 && out_ready) begin
        b = sbq.pop_front();
        checkCount++;
        if ({out_addr, out_data, out_last} !== {b.addr[4:0], b.data, b.last})
          $display("[TB] FAIL busy_beat got addr=%0d data=%h last=%b want addr=%0d data=%h last=%b",
                   out_addr, out_data, out_last, b.addr, b.data, b.last);
        else passCount++;
        beats++;
      end
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid === 1'b1 || busy === 1'b1 || done === 1'b1) extraValid++;
    end
    checkCount++;
    if (beats !== 32 || dones !== 1 || extraValid !== 0)
      $display("[TB] FAIL busy_ignore got beats=%0d dones=%0d postActive=%0d want 32 1 0", beats, dones, extraValid);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    int beats = 0, dones = 0;
    bit hit = 0;
    beat_t b;
    loadAndPush();
    out_ready = 1'b1;
    start = 1'b1;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid === 1'b1 && out_addr == 5'd10) hit = 1;
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    checkCount++;
    if (!hit || {out_valid, busy, done, rf_addr, out_addr, out_data, out_last} !== '0)
      $display("[TB] FAIL midreset_state got hit=%0d valid=%b busy=%b done=%b rf_addr=%0d addr=%0d data=%h want 1 and all 0",
               hit, out_valid, busy, done, rf_addr, out_addr, out_data, out_last);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if ({done, busy} !== 2'b00) $display("[TB] FAIL midreset_nodone got done=%b busy=%b want 0 0", done, busy);
    else passCount++;
    loadAndPush();
    start = 1'b1;
    for (int n = 0; n < 200 && dones == 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dones++;
      if (out_valid === 1'b1 && out_ready) begin
        b = sbq.pop_front();
        checkCount++;
        if ({out_addr, out_data, out_last} !== {b.addr[4:0], b.data, b.last})
          $display("[TB] FAIL midreset_beat got addr=%0d data=%h last=%b want addr=%0d data=%h last=%b",
                   out_addr, out_data, out_last, b.addr, b.data, b.last);
        else passCount++;
        beats++;
      end
    end
    checkCount++;
    if (beats !== 32 || dones !== 1) $display("[TB] FAIL midreset_counts got beats=%0d dones=%0d want 32 1", beats, dones);
    else passCount++;
    @(negedge clk);
  endtask

  task automatic test_nonpow2();
    int beats = 0, dones = 0, overrun = 0;
    beat_t b;
    sbq.delete();
    for (int i = 0; i < 8; i++) rf5[i] = 16'(i * 7 + 2);
    for (int i = 0; i < 5; i++) sbq.push_back('{i, rf5[i], i == 4});
    out_ready5 = 1'b1;
    start5 = 1'b1;
    for (int n = 0; n < 60 && dones == 0; n++) begin
      @(negedge clk);
      start5 = 1'b0;
      if (busy5 === 1'b1 && rf_addr5 > 3'd4) overrun++;
      if (done5 === 1'b1) dones++;
      if (out_valid5 === 1'b1 && out_ready5) begin
        if (sbq.size() == 0) begin
          overrun++;
        end else begin
          b = sbq.pop_front();
          checkCount++;
          if ({out_addr5, out_data5, out_last5} !== {b.addr[2:0], b.data, b.last})
            $display("[TB] FAIL depth5_beat got addr=%0d data=%h last=%b want addr=%0d data=%h last=%b",
                     out_addr5, out_data5, out_last5, b.addr, b.data, b.last);
          else passCount++;
        end
        beats++;
      end
    end
    checkCount++;
    if (beats !== 5 || dones !== 1 || overrun !== 0)
      $display("[TB] FAIL depth5_counts got beats=%0d dones=%0d overrun=%0d want 5 1 0", beats, dones, overrun);
    else passCount++;
    @(negedge clk);
  endtask

`ifdef REGDUMP_PARITY_EN
  task automatic test_parity();
    logic [15:0] vals [4] = '{16'h0001, 16'h0003, 16'hFFFF, 16'h8000};
    bit          par  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int dones = 0;
    for (int i = 0; i < 32; i++) rf[i] = 16'h0000;
    for (int i = 0; i < 4; i++) rf[i] = vals[i];
    out_ready = 1'b1;
    start = 1'b1;
    for (int n = 0; n < 200 && dones == 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dones++;
      if (out_valid === 1'b1 && out_addr < 5'd4) begin
        checkCount++;
        if (out_parity !== par[out_addr])
          $display("[TB] FAIL parity got %b for data=%h want %b", out_parity, out_data, par[out_addr]);
        else passCount++;
      end
    end
    checkCount++;
    if (dones !== 1) $display("[TB] FAIL parity_done got dones=%0d want 1", dones);
    else passCount++;
    @(negedge clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 16'h0;
    for (int i = 0; i < 8; i++) rf5[i] = 16'h0;
    test_reset();
    test_basic();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    test_nonpow2();
`ifdef REGDUMP_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
